mod_mem_arbiter: RTL

- Two-port arbiter that shares the single main-memory bus between the instruction cache (port 0) and the data cache (port 1).
- Sits between the cache memory-side interfaces (`memory_*` signals) and the main-memory/bus adapter.
- Grants one whole memory transaction at a time. Each transaction runs from request assertion to `memory_operation_stb`.
- Forwards the strobe and read data only to the granted port.

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/mod_mem_arb_pick.sv | 33 +++
 rtl/mod_mem_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port main-memory arbiter.
//   arb_state_e     : arbiter FSM states (idle, port 0 granted, port 1 granted)
//   ARB_PORT_*      : port indices (0 = icache, 1 = dcache)
//   mem_req_t       : one port's complete memory-side request, muxed as a unit
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BYTEENABLE_WIDTH
`define BYTEENABLE_WIDTH 4
`endif

package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT0 = 2'd1,
    ARB_GRANT1 = 2'd2
  } arb_state_e;

  localparam logic ARB_PORT_ICACHE = 1'b0;
  localparam logic ARB_PORT_DCACHE = 1'b1;

  typedef struct packed {
    logic [`XLEN-1:0]             address;
    logic [`XLEN-1:0]             writedata;
    logic                         read;
    logic                         write;
    logic [`BYTEENABLE_WIDTH-1:0] byteenable;
  } mem_req_t;

endpackage

// File: rtl/mod_mem_arb_pick.sv
// Combinational grant selection for the memory arbiter.
//   i_req0, i_req1 : pending requests from port 0 (icache) / port 1 (dcache)
//   i_last_grant   : port that completed the most recent transaction
//   o_grant        : port to grant (only meaningful when a request is pending)
//   o_conflict     : both ports are requesting at once
module mod_mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int DATA_PRIORITY = 1
) (
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic [1:0] i_last_grant,
  output logic       o_grant,
  output logic       o_conflict
);

  logic w_rr_pick;

  // Round-robin favours whichever port did not finish last.
  assign w_rr_pick  = (i_last_grant == 2'd0) ? ARB_PORT_DCACHE : ARB_PORT_ICACHE;
  assign o_conflict = i_req0 & i_req1;

  always_comb begin
    o_grant = ARB_PORT_ICACHE;
    if (i_req0 && i_req1) begin
      o_grant = (DATA_PRIORITY != 0) ? ARB_PORT_DCACHE : w_rr_pick;
    end else if (i_req1) begin
      o_grant = ARB_PORT_DCACHE;
    end
  end

endmodule

// File: rtl/mod_mem_arbiter.sv
// Two-port arbiter sharing the main-memory bus between icache (port 0) and
// dcache (port 1). One whole transaction is granted at a time; the granted
// port's request is muxed onto memory_*_o and the memory strobe/read data are
// routed back only to that port.
//   clk_i, rst_i              : clock, asynchronous active-high reset
//   pN_*_i / pN_*_o           : cache-side request/response of port N
//   memory_*_o / memory_*_i   : main-memory bus
//   conflict_o                : both ports requesting in the same idle cycle
module mod_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_PRIORITY = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [`XLEN-1:0]             p0_address_i,
  input  logic [`XLEN-1:0]             p0_writedata_i,
  input  logic                         p0_read_i,
  input  logic                         p0_write_i,
  input  logic [`BYTEENABLE_WIDTH-1:0] p0_byteenable_i,
  output logic [`XLEN-1:0]             p0_readdata_o,
  output logic                         p0_stb_o,
  input  logic [`XLEN-1:0]             p1_address_i,
  input  logic [`XLEN-1:0]             p1_writedata_i,
  input  logic                         p1_read_i,
  input  logic                         p1_write_i,
  input  logic [`BYTEENABLE_WIDTH-1:0] p1_byteenable_i,
  output logic [`XLEN-1:0]             p1_readdata_o,
  output logic                         p1_stb_o,
  output logic [`XLEN-1:0]             memory_address_o,
  output logic [`XLEN-1:0]             memory_writedata_o,
  output logic                         memory_read_o,
  output logic                         memory_write_o,
  output logic [`BYTEENABLE_WIDTH-1:0] memory_byteenable_o,
  input  logic [`XLEN-1:0]             memory_readdata_i,
  input  logic                         memory_operation_stb_i,
  output logic                         conflict_o
);

  arb_state_e r_state;
  arb_state_e w_next_state;
  logic [1:0] r_last_grant;
  logic [1:0] w_next_last;
  logic       w_req0;
  logic       w_req1;
  logic       w_grant;
  logic       w_conflict;
  logic       w_idle;
  logic       w_own0;
  logic       w_own1;
  mem_req_t   w_p0_req;
  mem_req_t   w_p1_req;
  mem_req_t   w_bus;

  assign w_req0 = p0_read_i | p0_write_i;
  assign w_req1 = p1_read_i | p1_write_i;

  mod_mem_arb_pick #(
    .DATA_PRIORITY(DATA_PRIORITY)
  ) u_pick (
    .i_req0      (w_req0),
    .i_req1      (w_req1),
    .i_last_grant(r_last_grant),
    .o_grant     (w_grant),
    .o_conflict  (w_conflict)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_last  = r_last_grant;
    case (r_state)
      ARB_IDLE: begin
        if (w_req0 || w_req1) begin
          w_next_state = (w_grant == ARB_PORT_DCACHE) ? ARB_GRANT1 : ARB_GRANT0;
        end
      end
      ARB_GRANT0: begin
        // Completion wins over a same-cycle drop of the request.
        if (memory_operation_stb_i) begin
          w_next_state = ARB_IDLE;
          w_next_last  = 2'd0;
        end else if (!w_req0) begin
          w_next_state = ARB_IDLE;
        end
      end
      ARB_GRANT1: begin
        if (memory_operation_stb_i) begin
          w_next_state = ARB_IDLE;
          w_next_last  = 2'd1;
        end else if (!w_req1) begin
          w_next_state = ARB_IDLE;
        end
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= 2'd1;
    end else begin
      r_state      <= w_next_state;
      r_last_grant <= w_next_last;
    end
  end

  assign w_idle = (r_state == ARB_IDLE);
  assign w_own0 = (r_state == ARB_GRANT0);
  assign w_own1 = (r_state == ARB_GRANT1);

  assign w_p0_req = '{address: p0_address_i, writedata: p0_writedata_i,
                      read: p0_read_i, write: p0_write_i,
                      byteenable: p0_byteenable_i};
  assign w_p1_req = '{address: p1_address_i, writedata: p1_writedata_i,
                      read: p1_read_i, write: p1_write_i,
                      byteenable: p1_byteenable_i};

  // Outputs are decoded straight from the state so an async reset clears the
  // bus immediately, without waiting for a clock edge.
  always_comb begin
    w_bus = '0;
    if (w_own0) begin
      w_bus = w_p0_req;
    end else if (w_own1) begin
      w_bus = w_p1_req;
    end
  end

  assign memory_address_o    = w_bus.address;
  assign memory_writedata_o  = w_bus.writedata;
  assign memory_read_o       = w_bus.read;
  assign memory_write_o      = w_bus.write;
  assign memory_byteenable_o = w_bus.byteenable;

  assign p0_stb_o      = w_own0 & memory_operation_stb_i;
  assign p1_stb_o      = w_own1 & memory_operation_stb_i;
  assign p0_readdata_o = w_own0 ? memory_readdata_i : '0;
  assign p1_readdata_o = w_own1 ? memory_readdata_i : '0;

  // Reset is held in IDLE, so mask the conflict flag while it is asserted.
  assign conflict_o = w_idle & w_conflict & ~rst_i;

endmodule
